// File: rtl/costas_lock_ctrl_if.sv
// Loop phase-error stream between the error-detect stage and the lock
// supervisor. There is no backpressure: a sample is consumed on every cycle
// that error_tvalid is high.
//   error_tdata  : signed loop phase error (two's complement, WIDTH bits)
//   error_tvalid : sample valid strobe
// master drives the stream; slave (the lock controller) observes it.
`timescale 1ns/1ps
interface costas_lock_ctrl_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] error_tdata;
  logic             error_tvalid;

  modport master (output error_tdata, output error_tvalid);
  modport slave  (input  error_tdata, input  error_tvalid);
endinterface

// File: rtl/costas_lock_ctrl.sv
// Supervisory controller for the Costas carrier-recovery loop.
// Owns the BPSK/QPSK select and the loop filter/NCO reset. It sequences a
// loop reset on enable or mode change, then measures mean |error| over
// fixed windows of 2^WIN_LOG2 valid samples to declare or drop lock. It
// retries acquisition after ACQ_TIMEOUT windows without lock.
// Ports:
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   en             : enable; low forces IDLE
//   mode_req       : requested mode, 1 = BPSK, 0 = QPSK
//   lock_thresh    : per-sample mean |error| below which a window is good
//   unlock_thresh  : per-sample mean |error| above which a window is bad
//   err_if         : loop phase-error stream (slave)
//   is_bpsk        : registered mode to the error-detect stage
//   loop_rst       : active-high reset to loop filter/NCO
//   locked         : lock indication
//   state          : IDLE=0, RESET_LOOP=1, ACQUIRE=2, LOCKED=3
//   retry_cnt      : acquisition timeouts, saturating at 255
`timescale 1ns/1ps
module costas_lock_ctrl #(
  parameter int WIDTH          = 16,
  parameter int WIN_LOG2       = 6,
  parameter int RST_CYCLES     = 16,
  parameter int LOCK_WINDOWS   = 4,
  parameter int UNLOCK_WINDOWS = 2,
  parameter int ACQ_TIMEOUT    = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 mode_req,
  input  logic [WIDTH-2:0]     lock_thresh,
  input  logic [WIDTH-2:0]     unlock_thresh,
  costas_lock_ctrl_if.slave    err_if,
  output logic                 is_bpsk,
  output logic                 loop_rst,
  output logic                 locked,
  output logic [1:0]           state,
  output logic [7:0]           retry_cnt
);
  localparam int ABS_W = WIDTH - 1;
  localparam int ACC_W = ABS_W + WIN_LOG2;
  localparam int RW    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int GW    = $clog2(LOCK_WINDOWS + 1);
  localparam int BW    = $clog2(UNLOCK_WINDOWS + 1);
  localparam int TW    = $clog2(ACQ_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RESET_LOOP = 2'd1,
    ACQUIRE    = 2'd2,
    LOCKED     = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              is_bpsk_d, loop_rst_d, locked_d;
  logic [7:0]        retry_d;
  logic [RW-1:0]     rst_cnt_q, rst_cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [WIN_LOG2-1:0] samp_q, samp_d;
  logic [GW-1:0]     good_q, good_d, good_inc;
  logic [BW-1:0]     bad_q, bad_d, bad_inc;
  logic [TW-1:0]     win_q, win_d, win_inc;

  logic [ABS_W-1:0]  neg_low, abs_err;
  logic [ACC_W-1:0]  sum;
  logic              win_close, good_win, bad_win, mode_chg;
  logic              to_reset, to_acq;

  // Low bits of the negation depend only on the low input bits; a negative
  // sample whose low bits are all zero is the most negative value, which
  // saturates to the largest magnitude.
  assign neg_low = ~err_if.error_tdata[ABS_W-1:0] + 1'b1;

  always_comb begin
    if (!err_if.error_tdata[WIDTH-1])
      abs_err = err_if.error_tdata[ABS_W-1:0];
    else if (err_if.error_tdata[ABS_W-1:0] == '0)
      abs_err = '1;
    else
      abs_err = neg_low;
  end

  assign sum       = acc_q + {{WIN_LOG2{1'b0}}, abs_err};
  assign good_win  = sum < {lock_thresh, {WIN_LOG2{1'b0}}};
  assign bad_win   = sum > {unlock_thresh, {WIN_LOG2{1'b0}}};
  assign win_close = err_if.error_tvalid && (samp_q == '1);
  assign mode_chg  = mode_req != is_bpsk;
  assign good_inc  = good_q + 1'b1;
  assign bad_inc   = bad_q + 1'b1;
  assign win_inc   = win_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    is_bpsk_d  = is_bpsk;
    loop_rst_d = loop_rst;
    locked_d   = locked;
    retry_d    = retry_cnt;
    rst_cnt_d  = rst_cnt_q;
    acc_d      = acc_q;
    samp_d     = samp_q;
    good_d     = good_q;
    bad_d      = bad_q;
    win_d      = win_q;
    to_reset   = 1'b0;
    to_acq     = 1'b0;

    if (!en) begin
      state_d    = IDLE;
      loop_rst_d = 1'b1;
      locked_d   = 1'b0;
      rst_cnt_d  = '0;
      acc_d      = '0;
      samp_d     = '0;
      good_d     = '0;
      bad_d      = '0;
      win_d      = '0;
      if (state_q == IDLE) is_bpsk_d = mode_req;
    end else begin
      case (state_q)
        IDLE: begin
          is_bpsk_d = mode_req;
          to_reset  = 1'b1;
        end
        RESET_LOOP: begin
          if (mode_chg) begin
            is_bpsk_d = mode_req;
            to_reset  = 1'b1;
          end else if (rst_cnt_q == RW'(RST_CYCLES - 1)) begin
            to_acq = 1'b1;
          end else begin
            rst_cnt_d = rst_cnt_q + 1'b1;
          end
        end
        ACQUIRE, LOCKED: begin
          if (mode_chg) begin
            is_bpsk_d = mode_req;
            to_reset  = 1'b1;
          end else if (err_if.error_tvalid) begin
            if (!win_close) begin
              acc_d  = sum;
              samp_d = samp_q + 1'b1;
            end else begin
              acc_d  = '0;
              samp_d = '0;
              if (state_q == ACQUIRE) begin
                good_d = good_win ? good_inc : '0;
                win_d  = win_inc;
                // Lock wins over timeout on the same window.
                if (good_win && (good_inc == GW'(LOCK_WINDOWS))) begin
                  state_d  = LOCKED;
                  locked_d = 1'b1;
                  bad_d    = '0;
                end else if (win_inc == TW'(ACQ_TIMEOUT)) begin
                  to_reset = 1'b1;
                  if (retry_cnt != 8'hFF) retry_d = retry_cnt + 1'b1;
                end
              end else begin
                bad_d = bad_win ? bad_inc : '0;
                if (bad_win && (bad_inc == BW'(UNLOCK_WINDOWS))) to_acq = 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end

    // Shared entry actions; any partial window is discarded on entry.
    if (to_reset || to_acq) begin
      state_d    = to_reset ? RESET_LOOP : ACQUIRE;
      loop_rst_d = to_reset;
      locked_d   = 1'b0;
      rst_cnt_d  = '0;
      acc_d      = '0;
      samp_d     = '0;
      good_d     = '0;
      bad_d      = '0;
      win_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      is_bpsk   <= 1'b1;
      loop_rst  <= 1'b1;
      locked    <= 1'b0;
      retry_cnt <= '0;
      rst_cnt_q <= '0;
      acc_q     <= '0;
      samp_q    <= '0;
      good_q    <= '0;
      bad_q     <= '0;
      win_q     <= '0;
    end else begin
      state_q   <= state_d;
      is_bpsk   <= is_bpsk_d;
      loop_rst  <= loop_rst_d;
      locked    <= locked_d;
      retry_cnt <= retry_d;
      rst_cnt_q <= rst_cnt_d;
      acc_q     <= acc_d;
      samp_q    <= samp_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
      win_q     <= win_d;
    end
  end

  assign state = state_q;
endmodule

// File: tb/tb_costas_lock_ctrl.sv
// Directed bench for costas_lock_ctrl. Expected output snapshots are queued
// before each stimulus step and popped/compared once the step's edge has
// occurred. A second instance with tiny windows covers retry saturation.
`timescale 1ns/1ps
module tb_costas_lock_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, mode_req, en2;
  logic [14:0] lock_th, unlock_th, zero_th;
  logic        bpsk_o, lrst_o, lock_o;
  logic [1:0]  state_o;
  logic [7:0]  retry_o;
  logic        s_bpsk, s_lrst, s_lock;
  logic [1:0]  s_state;
  logic [7:0]  s_retry;
  int          vectors = 0;
  int          miscompares = 0;

  typedef struct {
    string      tag;
    logic [1:0] st;
    logic       lk, bp, lr;
    logic [7:0] rc;
  } exp_t;
  exp_t sbq[$];

  costas_lock_ctrl_if #(.WIDTH(16)) m_if ();
  costas_lock_ctrl_if #(.WIDTH(16)) s_if ();

  always #5 clk = ~clk;

  costas_lock_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode_req(mode_req),
    .lock_thresh(lock_th), .unlock_thresh(unlock_th), .err_if(m_if),
    .is_bpsk(bpsk_o), .loop_rst(lrst_o), .locked(lock_o),
    .state(state_o), .retry_cnt(retry_o)
  );

  costas_lock_ctrl #(
    .WIDTH(16), .WIN_LOG2(2), .RST_CYCLES(2), .LOCK_WINDOWS(4),
    .UNLOCK_WINDOWS(2), .ACQ_TIMEOUT(1)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en2), .mode_req(1'b1),
    .lock_thresh(zero_th), .unlock_thresh(zero_th), .err_if(s_if),
    .is_bpsk(s_bpsk), .loop_rst(s_lrst), .locked(s_lock),
    .state(s_state), .retry_cnt(s_retry)
  );

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [1:0] st, input logic lk,
                      input logic bp, input logic lr, input logic [7:0] rc);
    exp_t e;
    e.tag = tag; e.st = st; e.lk = lk; e.bp = bp; e.lr = lr; e.rc = rc;
    sbq.push_back(e);
  endtask

  task automatic check_sb();
    exp_t e;
    if (sbq.size() == 0) begin
      cmp("sb_underflow", 32'(sbq.size()), 32'd1);
      return;
    end
    e = sbq.pop_front();
    cmp({e.tag, "_state"},    32'(state_o), 32'(e.st));
    cmp({e.tag, "_locked"},   32'(lock_o),  32'(e.lk));
    cmp({e.tag, "_is_bpsk"},  32'(bpsk_o),  32'(e.bp));
    cmp({e.tag, "_loop_rst"}, 32'(lrst_o),  32'(e.lr));
    cmp({e.tag, "_retry"},    32'(retry_o), 32'(e.rc));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int d);
    m_if.error_tvalid = v;
    m_if.error_tdata  = 16'(d);
    tick();
  endtask

  // Called just after the edge entering RESET_LOOP; counts cycles spent there.
  task automatic count_reset_loop(input string tag, input int expn);
    int n = 0;
    while (state_o == 2'd1 && n < 200) begin
      cmp({tag, "_lr_hi"}, 32'(lrst_o), 32'd1);
      n++;
      drive(1'b0, 0);
    end
    cmp({tag, "_len"}, 32'(n), 32'(expn));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; en2 = 1'b0; mode_req = 1'b1;
    lock_th = 15'd100; unlock_th = 15'd200; zero_th = '0;
    m_if.error_tvalid = 1'b0; m_if.error_tdata = '0;
    s_if.error_tvalid = 1'b1; s_if.error_tdata = 16'd1000;

    push("reset", 2'd0, 1'b0, 1'b1, 1'b1, 8'd0);
    tick(); tick();
    check_sb();
    rst_n = 1'b1;
    push("idle", 2'd0, 1'b0, 1'b1, 1'b1, 8'd0);
    tick();
    check_sb();

    // Enable -> RESET_LOOP for 16 cycles -> ACQUIRE
    en = 1'b1;
    push("enter", 2'd1, 1'b0, 1'b1, 1'b1, 8'd0);
    drive(1'b0, 0);
    check_sb();
    count_reset_loop("init", 16);
    push("acq", 2'd2, 1'b0, 1'b1, 1'b0, 8'd0);
    check_sb();

    // Lock on sample 256 with |error| = 50 < 100
    push("pre_lock", 2'd2, 1'b0, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 255; i++) drive(1'b1, (i % 2 == 1) ? -50 : 50);
    check_sb();
    push("lock", 2'd3, 1'b1, 1'b1, 1'b0, 8'd0);
    drive(1'b1, -50);
    check_sb();

    // One bad window then a clean one keeps lock
    push("bad_good", 2'd3, 1'b1, 1'b1, 1'b0, 8'd0);
    repeat (64) drive(1'b1, 300);
    repeat (64) drive(1'b1, 0);
    check_sb();
    // Two consecutive bad windows drop lock on sample 128
    push("pre_unlock", 2'd3, 1'b1, 1'b1, 1'b0, 8'd0);
    repeat (127) drive(1'b1, 300);
    check_sb();
    push("unlock", 2'd2, 1'b0, 1'b1, 1'b0, 8'd0);
    drive(1'b1, 300);
    check_sb();

    // Sum exactly lock_thresh<<6 is not good and restarts the good count
    push("eq_win", 2'd2, 1'b0, 1'b1, 1'b0, 8'd0);
    repeat (192) drive(1'b1, -50);
    repeat (64) drive(1'b1, 100);
    check_sb();
    push("eq_after3", 2'd2, 1'b0, 1'b1, 1'b0, 8'd0);
    repeat (192) drive(1'b1, 50);
    check_sb();
    push("eq_lock", 2'd3, 1'b1, 1'b1, 1'b0, 8'd0);
    repeat (64) drive(1'b1, -50);
    check_sb();

    // Mode change while LOCKED, then again mid-RESET_LOOP
    mode_req = 1'b0;
    push("mode_q", 2'd1, 1'b0, 1'b0, 1'b1, 8'd0);
    drive(1'b0, 0);
    check_sb();
    repeat (5) drive(1'b0, 0);
    mode_req = 1'b1;
    push("mode_b", 2'd1, 1'b0, 1'b1, 1'b1, 8'd0);
    drive(1'b0, 0);
    check_sb();
    count_reset_loop("mode", 16);
    push("acq2", 2'd2, 1'b0, 1'b1, 1'b0, 8'd0);
    check_sb();

    // Relock, then most-negative sample saturation
    push("relock", 2'd3, 1'b1, 1'b1, 1'b0, 8'd0);
    repeat (256) drive(1'b1, 0);
    check_sb();
    unlock_th = 15'd32767;
    push("abs_eq", 2'd3, 1'b1, 1'b1, 1'b0, 8'd0);
    repeat (128) drive(1'b1, -32768);
    check_sb();
    unlock_th = 15'd32766;
    push("abs_pre", 2'd3, 1'b1, 1'b1, 1'b0, 8'd0);
    repeat (127) drive(1'b1, -32768);
    check_sb();
    push("abs_bad", 2'd2, 1'b0, 1'b1, 1'b0, 8'd0);
    drive(1'b1, -32768);
    check_sb();

    // Acquisition timeout after 64 windows of |error| = 1000
    push("to_pre", 2'd2, 1'b0, 1'b1, 1'b0, 8'd0);
    repeat (4095) drive(1'b1, 1000);
    check_sb();
    push("timeout", 2'd1, 1'b0, 1'b1, 1'b1, 8'd1);
    drive(1'b1, 1000);
    check_sb();
    count_reset_loop("retry", 16);
    push("to_acq", 2'd2, 1'b0, 1'b1, 1'b0, 8'd1);
    check_sb();

    // en low in ACQUIRE -> IDLE; mode follows mode_req there
    en = 1'b0;
    push("en_low", 2'd0, 1'b0, 1'b1, 1'b1, 8'd1);
    drive(1'b1, 0);
    check_sb();
    mode_req = 1'b0;
    push("idle_mode", 2'd0, 1'b0, 1'b0, 1'b1, 8'd1);
    drive(1'b0, 0);
    check_sb();

    // Retry saturation: small instance times out at edge 1+6k
    en2 = 1'b1;
    repeat (60) tick();
    cmp("sat_k9", 32'(s_retry), 32'd9);
    tick();
    cmp("sat_k10", 32'(s_retry), 32'd10);
    cmp("sat_state", 32'(s_state), 32'd1);
    repeat (1740) tick();
    cmp("sat_255", 32'(s_retry), 32'd255);
    repeat (12) tick();
    cmp("sat_hold", 32'(s_retry), 32'd255);
    en2 = 1'b0;

    // Async reset mid-LOCKED (QPSK mode so is_bpsk visibly resets)
    en = 1'b1;
    push("re_enter", 2'd1, 1'b0, 1'b0, 1'b1, 8'd1);
    drive(1'b0, 0);
    check_sb();
    count_reset_loop("re", 16);
    push("re_lock", 2'd3, 1'b1, 1'b0, 1'b0, 8'd1);
    repeat (256) drive(1'b1, 0);
    check_sb();
    #2;
    push("async_rst", 2'd0, 1'b0, 1'b1, 1'b1, 8'd0);
    rst_n = 1'b0;
    #1;
    check_sb();

    cmp("sb_empty", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
